uart_rx: RTL
============

# uart_rx

Serial receiver that consumes the frame stream produced by the UART transmitter (start bit, LSB-first data, optional parity, one stop bit). It oversamples the line by a runtime prescale, majority-votes each bit, checks parity and stop bit, and presents the received word as a one-cycle-valid parallel output. It sits at the receive end of the serial link and feeds the system's register/control logic.

## Interface
- width, 8, data bits per frame
- PRESCALE_W, 6, width of the Prescale input
- CLK  input  1  oversampling clock, rising edge
- Reset  input  1  asynchronous, active-low reset
- Rx_in  input  1  serial line, idle high
- Prescale  input  PRESCALE_W  clock cycles per bit; legal values 8, 16, 32
- Parity_EN  input  1  1: frame carries a parity bit
- Parity_type  input  1  0: even parity, 1: odd parity (matches the transmitter)
- P_data  output  width  last good received word
- Data_valid  output  1  one-cycle pulse, P_data updated this cycle
- Parity_error  output  1  one-cycle pulse, parity mismatch on the frame just ended
- Stop_error  output  1  one-cycle pulse, stop bit sampled low

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: Rx_in low → START. This cycle is edge count 0 of the start bit. Prescale, Parity_EN and Parity_type are latched here and held for the whole frame.
- Edge counter: runs 0..P-1 within each bit and wraps at P-1. The bit counter advances on the wrap.
- Sampling: Rx_in is sampled at edge counts P/2-1, P/2 and P/2+1. The bit value is the 2-of-3 majority.
- START: if the voted value is 1 (glitch), return to IDLE on the next cycle. No outputs are produced. Otherwise stay in START until the wrap, then go to DATA.
- DATA: shift the voted bits in LSB-first. After `width` bits, go to PARITY if Parity_EN is set, else to STOP.
- PARITY: compute the expected parity as `^data` for even or `~^data` for odd, and compare it with the voted bit.
- STOP: a voted value of 0 is a stop error. On the stop-bit wrap:
  - Outputs are registered.
  - Data_valid=1 and P_data=data only when there is neither a parity error nor a stop error.
  - Otherwise the matching error pulses assert, and P_data holds its old value.
  - Parity_error and Stop_error may assert together.
- After the stop-bit wrap, the FSM is in IDLE the next cycle. If Rx_in is already low there, that cycle is count 0 of the next frame, so back-to-back frames are supported with zero idle bits.
- A changing Prescale or Parity_EN mid-frame has no effect until the next IDLE→START.
- Reset asserted at any time:
  - FSM goes to IDLE and both counters clear.
  - P_data=0, Data_valid=0, Parity_error=0, Stop_error=0.
  - A partial frame is discarded.

## Timing
- N = 1 + width + Parity_EN + 1 bits per frame.
- The falling edge seen in IDLE at cycle 0 gives Data_valid or the error pulse at cycle N·P. Each pulse is exactly 1 cycle.
- A glitch abort decision is made at count P/2+1; the FSM is in IDLE at cycle P/2+2.
- Every output is registered; there are no combinational paths from inputs to outputs.
- Throughput: one word per N·P cycles.

## Configuration
- UART_RX_SYNC_EN defined: Rx_in passes through a 2-flop synchronizer (reset value 1) before the FSM. All output timings shift by +2 cycles, and the glitch-abort IDLE cycle becomes P/2+4.
- UART_RX_SYNC_EN undefined: Rx_in is used directly, and the line is treated as already synchronous to CLK.

## Structure
- Shared package uart_pkg holds:
  - state encoding localparams (IDLE, START, DATA, PARITY, STOP)
  - legal prescale constants
  - the parity-type encoding shared with the transmitter.
- One sub-module, uart_rx_sampler, contains:
  - the edge counter
  - the three-point sample capture
  - the majority vote, output as a voted bit plus a sample_done strobe.
- The FSM, shift register, parity check and output registers stay in uart_rx.

## Test plan
- Prescale=8, Parity_EN=1, Parity_type=0, send 0xA5 with parity bit 0 → Data_valid at cycle 88, P_data=0xA5, no error pulses.
- Prescale=8, Rx_in low for cycles 0–2 then high → no output pulses, FSM back in IDLE by cycle 6.
- Prescale=16, Parity_EN=1, Parity_type=1, send 0x3C with a wrong parity bit → Parity_error pulse at cycle 176, Data_valid=0, P_data unchanged.
- Prescale=16, Parity_EN=0, frames 0x01 then 0xFF back-to-back → Data_valid at cycles 160 and 320 with P_data 0x01 and 0xFF.
- Prescale=8, send 0x5A with its stop bit driven 0, plus one flipped sample at count P/2 in data bit 3 → Stop_error at cycle 80, data bit still decoded correctly by the vote.
- Reset pulsed mid-DATA → all outputs 0 immediately; the next clean frame decodes normally.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: UART state encoding, legal prescale values and parity encoding shared by the link.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam int unsigned PRESCALE_8  = 8;
    localparam int unsigned PRESCALE_16 = 16;
    localparam int unsigned PRESCALE_32 = 32;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    function automatic logic is_legal_prescale(input int unsigned v);
        return v == PRESCALE_8 || v == PRESCALE_16 || v == PRESCALE_32;
    endfunction

    // Expected parity bit from the XOR-reduction of the data word.
    function automatic logic parity_bit(input logic xor_red, input logic ptype);
        return xor_red ^ (ptype == PARITY_ODD);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: per-bit edge counter, three-point capture around mid-bit and 2-of-3 vote.
module uart_rx_sampler #(
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    input  logic                  rx,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  wrap,
    output logic                  sample_done,
    output logic                  bit_val
);

    logic [PRESCALE_W-1:0] cnt;
    logic [PRESCALE_W-1:0] half;
    logic [1:0]            s;

    assign half        = prescale >> 1;
    assign wrap        = cnt == prescale - 1'b1;
    assign sample_done = cnt == half + 1'b1;
    // Third sample is the live line, so the vote resolves on the last sample cycle.
    assign bit_val     = (s[0] & s[1]) | (s[0] & rx) | (s[1] & rx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            s   <= '0;
        end else begin
            cnt <= (run && !wrap) ? cnt + 1'b1 : '0;
            if (cnt == half - 1'b1) s[0] <= rx;
            if (cnt == half) s[1] <= rx;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with majority vote, parity and stop checks.
// Define UART_RX_SYNC_EN to pass Rx_in through a 2-flop synchronizer (adds 2 cycles latency).
module uart_rx
    import uart_pkg::*;
#(
    parameter int width      = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  Rx_in,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  Parity_EN,
    input  logic                  Parity_type,
    output logic [width-1:0]      P_data,
    output logic                  Data_valid,
    output logic                  Parity_error,
    output logic                  Stop_error
);

    localparam int BW = $clog2(width);

    logic                  rx;
    rx_state_t             state;
    logic [PRESCALE_W-1:0] p;
    logic                  pen;
    logic                  ptype;
    logic [width-1:0]      shreg;
    logic [BW-1:0]         bit_idx;
    logic                  vbit;
    logic                  par_err;
    logic                  run;
    logic                  wrap;
    logic                  done;
    logic                  bit_val;
    logic                  last;
    logic                  good;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync;
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) sync <= 2'b11;
        else sync <= {sync[0], Rx_in};
    end
    assign rx = sync[1];
`else
    assign rx = Rx_in;
`endif

    // Counter runs from the IDLE cycle that sees the falling edge; a start glitch clears it.
    assign run  = (state == IDLE) ? !rx : !(state == START && done && bit_val);
    assign last = bit_idx == BW'(width - 1);
    assign good = !par_err && vbit;

    uart_rx_sampler #(.PRESCALE_W(PRESCALE_W)) u_sampler (
        .clk         (CLK),
        .rst_n       (Reset),
        .run         (run),
        .rx          (rx),
        .prescale    (p),
        .wrap        (wrap),
        .sample_done (done),
        .bit_val     (bit_val)
    );

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state        <= IDLE;
            p            <= PRESCALE_W'(PRESCALE_8);
            pen          <= 1'b0;
            ptype        <= PARITY_EVEN;
            shreg        <= '0;
            bit_idx      <= '0;
            vbit         <= 1'b1;
            par_err      <= 1'b0;
            P_data       <= '0;
            Data_valid   <= 1'b0;
            Parity_error <= 1'b0;
            Stop_error   <= 1'b0;
        end else begin
            Data_valid   <= 1'b0;
            Parity_error <= 1'b0;
            Stop_error   <= 1'b0;
            if (done) vbit <= bit_val;
            case (state)
                IDLE: if (!rx) begin
                    state   <= START;
                    p       <= is_legal_prescale(32'(Prescale)) ? Prescale : PRESCALE_W'(PRESCALE_16);
                    pen     <= Parity_EN;
                    ptype   <= Parity_type;
                    par_err <= 1'b0;
                    bit_idx <= '0;
                end
                START: begin
                    if (done && bit_val) state <= IDLE;
                    else if (wrap) state <= DATA;
                end
                DATA: begin
                    if (done) shreg <= {bit_val, shreg[width-1:1]};
                    if (wrap) begin
                        bit_idx <= last ? '0 : bit_idx + 1'b1;
                        if (last) state <= pen ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (done) par_err <= bit_val != parity_bit(^shreg, ptype);
                    if (wrap) state <= STOP;
                end
                STOP: if (wrap) begin
                    state        <= IDLE;
                    Data_valid   <= good;
                    Parity_error <= par_err;
                    Stop_error   <= !vbit;
                    if (good) P_data <= shreg;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
